// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock supervisor: pulses PLL reset, waits for debounced lock (timeout + retry), raises clk_ready.
// Latency: pll_locked is seen 2 refclk edges late (synchronizer); all outputs are registered.
// Backpressure: none, the block has no flow-controlled interfaces.
//
// Ports:
//   refclk        reference clock, the only clock; rst_n synchronous active-low reset
//   pll_locked    PLL lock indication, asynchronous to refclk
//   force_relock  one-cycle request to re-reset the PLL (ignored while already in RESET)
//   pll_rst       active-high reset to the PLL
//   clk_ready     PLL outputs valid and stable
//   lock_lost     one-cycle pulse on lock loss while ready
//   lock_timeout  one-cycle pulse when lock does not arrive in time
//   lost_cnt      saturating count of lock_lost events
//   timeout_cnt   saturating count of lock_timeout events
//   state         debug view of the FSM: 0 RESET, 1 WAIT_LOCK, 2 STABLE, 3 READY
module pll_lock_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int CNT_W        = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             force_relock,
    output logic             pll_rst,
    output logic             clk_ready,
    output logic             lock_lost,
    output logic             lock_timeout,
    output logic [CNT_W-1:0] lost_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_READY     = 2'd3
    } state_t;

    // One shared cycle counter; it only has to reach (largest limit - 1).
    localparam int MAX_AB  = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
    localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             pll_rst_q, pll_rst_d;
    logic             clk_ready_q, clk_ready_d;
    logic             lock_lost_q, lock_lost_d;
    logic             lock_timeout_q, lock_timeout_d;
    logic [CNT_W-1:0] lost_cnt_q, lost_cnt_d;
    logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;

    logic             locked_s;
    logic             lost_evt;
    logic             timeout_evt;

    assign locked_s = sync2_q;

    always_comb begin
        sync1_d       = pll_locked;
        sync2_d       = sync1_q;
        state_d       = state_q;
        lost_evt      = 1'b0;
        timeout_evt   = 1'b0;
        lost_cnt_d    = lost_cnt_q;
        timeout_cnt_d = timeout_cnt_q;

        case (state_q)
            ST_RESET: begin
                if (tmr_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock seen on the timeout cycle wins over the timeout.
                if (locked_s) begin
                    state_d = ST_STABLE;
                end else if (tmr_q == TIMEOUT_LAST) begin
                    state_d     = ST_RESET;
                    timeout_evt = 1'b1;
                end
                if (force_relock) begin
                    state_d = ST_RESET;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (tmr_q == STABLE_LAST) begin
                    state_d = ST_READY;
                end
                if (force_relock) begin
                    state_d = ST_RESET;
                end
            end
            ST_READY: begin
                // A lock loss is still reported when a relock is forced on the same cycle.
                if (!locked_s) begin
                    state_d  = ST_RESET;
                    lost_evt = 1'b1;
                end
                if (force_relock) begin
                    state_d = ST_RESET;
                end
            end
            default: state_d = ST_RESET;
        endcase

        // Counter restarts on every state change so each state measures its own dwell time.
        tmr_d = (state_d != state_q) ? '0 : tmr_q + TW'(1);

        pll_rst_d      = (state_d == ST_RESET);
        clk_ready_d    = (state_d == ST_READY);
        lock_lost_d    = lost_evt;
        lock_timeout_d = timeout_evt;

        if (lost_evt && (lost_cnt_q != '1)) begin
            lost_cnt_d = lost_cnt_q + CNT_W'(1);
        end
        if (timeout_evt && (timeout_cnt_q != '1)) begin
            timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q        <= ST_RESET;
            tmr_q          <= '0;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            pll_rst_q      <= 1'b1;
            clk_ready_q    <= 1'b0;
            lock_lost_q    <= 1'b0;
            lock_timeout_q <= 1'b0;
            lost_cnt_q     <= '0;
            timeout_cnt_q  <= '0;
        end else begin
            state_q        <= state_d;
            tmr_q          <= tmr_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            pll_rst_q      <= pll_rst_d;
            clk_ready_q    <= clk_ready_d;
            lock_lost_q    <= lock_lost_d;
            lock_timeout_q <= lock_timeout_d;
            lost_cnt_q     <= lost_cnt_d;
            timeout_cnt_q  <= timeout_cnt_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign clk_ready    = clk_ready_q;
    assign lock_lost    = lock_lost_q;
    assign lock_timeout = lock_timeout_q;
    assign lost_cnt     = lost_cnt_q;
    assign timeout_cnt  = timeout_cnt_q;
    assign state        = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Testbench for pll_lock_ctrl: scripted vector table, hand-written corner sequences, random stimulus.
// Latency: every tick drives inputs, lets one refclk edge pass, checks outputs on the falling edge.
// Backpressure: not applicable.
module tb_pll_lock_ctrl;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_STABLE  = 8;
    localparam int LOCK_TIMEOUT = 32;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = 15;

    localparam int P_RESET  = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_READY  = 3;

    logic             refclk = 1'b0;
    logic             rst_n;
    logic             pll_locked;
    logic             force_relock;
    logic             pll_rst;
    logic             clk_ready;
    logic             lock_lost;
    logic             lock_timeout;
    logic [CNT_W-1:0] lost_cnt;
    logic [CNT_W-1:0] timeout_cnt;
    logic [1:0]       state;

    int vectors     = 0;
    int miscompares = 0;

    always #5 refclk = ~refclk;

    pll_lock_ctrl #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_STABLE (LOCK_STABLE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .force_relock(force_relock),
        .pll_rst     (pll_rst),
        .clk_ready   (clk_ready),
        .lock_lost   (lock_lost),
        .lock_timeout(lock_timeout),
        .lost_cnt    (lost_cnt),
        .timeout_cnt (timeout_cnt),
        .state       (state)
    );

    // Reference model: phase plus the edge number on which it was entered; dwell time is
    // the difference of edge numbers. The synchronizer is a two-deep sample queue.
    int     m_phase = P_RESET;
    longint m_cyc   = 0;
    longint m_entry = 0;
    bit     m_lost  = 1'b0;
    bit     m_to    = 1'b0;
    int     m_lcnt  = 0;
    int     m_tcnt  = 0;
    bit     m_pipe[$];

    task automatic model_edge(input bit rn, input bit lk, input bit fr);
        bit     ls;
        longint age;
        int     nxt;
        bit     lost_ev;
        bit     to_ev;
        m_cyc++;
        lost_ev = 1'b0;
        to_ev   = 1'b0;
        if (!rn) begin
            m_phase = P_RESET;
            m_entry = m_cyc;
            m_lcnt  = 0;
            m_tcnt  = 0;
            m_pipe.delete();
            m_pipe.push_back(1'b0);
            m_pipe.push_back(1'b0);
        end else begin
            ls = m_pipe.pop_front();
            m_pipe.push_back(lk);
            age = m_cyc - m_entry;
            nxt = m_phase;
            if (m_phase == P_RESET) begin
                if (age >= RST_CYCLES) nxt = P_WAIT;
            end else if (m_phase == P_WAIT) begin
                if (ls) nxt = P_STABLE;
                else if (age >= LOCK_TIMEOUT) begin
                    nxt   = P_RESET;
                    to_ev = 1'b1;
                end
            end else if (m_phase == P_STABLE) begin
                if (!ls) nxt = P_WAIT;
                else if (age >= LOCK_STABLE) nxt = P_READY;
            end else begin
                if (!ls) begin
                    nxt     = P_RESET;
                    lost_ev = 1'b1;
                end
            end
            if (fr && (m_phase != P_RESET)) nxt = P_RESET;
            if (nxt != m_phase) begin
                m_phase = nxt;
                m_entry = m_cyc;
            end
            if (lost_ev) m_lcnt = (m_lcnt + 1 > CNT_MAX) ? CNT_MAX : m_lcnt + 1;
            if (to_ev)   m_tcnt = (m_tcnt + 1 > CNT_MAX) ? CNT_MAX : m_tcnt + 1;
        end
        m_lost = lost_ev;
        m_to   = to_ev;
    endtask

    function automatic logic [13:0] dut_vec();
        return {pll_rst, clk_ready, lock_lost, lock_timeout, state, lost_cnt, timeout_cnt};
    endfunction

    function automatic logic [13:0] model_vec();
        return {(m_phase == P_RESET), (m_phase == P_READY), m_lost, m_to,
                2'(m_phase), 4'(m_lcnt), 4'(m_tcnt)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick(input bit rn, input bit lk, input bit fr);
        rst_n        = rn;
        pll_locked   = lk;
        force_relock = fr;
        @(posedge refclk);
        model_edge(rn, lk, fr);
        @(negedge refclk);
        chk($sformatf("model@edge%0d", m_cyc), 32'(dut_vec()), 32'(model_vec()));
    endtask

    // Vector record: inputs held for 'hold' edges, then outputs compared once.
    // exp = {pll_rst, clk_ready, lock_lost, lock_timeout, state[1:0], lost_cnt[3:0], timeout_cnt[3:0]}
    typedef struct packed {
        logic        rn;
        logic        lk;
        logic        fr;
        logic [7:0]  hold;
        logic [13:0] exp;
    } vec_t;

    function automatic vec_t v(bit rn, bit lk, bit fr, int hold,
                               bit r, bit c, bit l, bit t, int st, int lc, int tc);
        vec_t x;
        x.rn   = rn;
        x.lk   = lk;
        x.fr   = fr;
        x.hold = 8'(hold);
        x.exp  = {r, c, l, t, 2'(st), 4'(lc), 4'(tc)};
        return x;
    endfunction

    vec_t tbl[$];

    initial begin
        int run_left;
        bit lk_r;
        run_left     = 0;
        lk_r         = 1'b0;
        rst_n        = 1'b0;
        pll_locked   = 1'b0;
        force_relock = 1'b0;

        // Power-up, first lock (pll_rst falls after edge 4, pll_locked raised before edge 7)
        tbl.push_back(v(0,0,0,3, 1,0,0,0,0,0,0));
        tbl.push_back(v(1,0,0,3, 1,0,0,0,0,0,0));
        tbl.push_back(v(1,0,0,1, 0,0,0,0,1,0,0));
        tbl.push_back(v(1,0,0,2, 0,0,0,0,1,0,0));
        tbl.push_back(v(1,1,0,2, 0,0,0,0,1,0,0));
        tbl.push_back(v(1,1,0,1, 0,0,0,0,2,0,0));
        tbl.push_back(v(1,1,0,7, 0,0,0,0,2,0,0));
        tbl.push_back(v(1,1,0,1, 0,1,0,0,3,0,0));
        // Lock loss in READY, 4-cycle reset pulse, relock
        tbl.push_back(v(1,0,0,2, 0,1,0,0,3,0,0));
        tbl.push_back(v(1,0,0,1, 1,0,1,0,0,1,0));
        tbl.push_back(v(1,1,0,1, 1,0,0,0,0,1,0));
        tbl.push_back(v(1,1,0,2, 1,0,0,0,0,1,0));
        tbl.push_back(v(1,1,0,1, 0,0,0,0,1,1,0));
        tbl.push_back(v(1,1,0,1, 0,0,0,0,2,1,0));
        tbl.push_back(v(1,1,0,7, 0,0,0,0,2,1,0));
        tbl.push_back(v(1,1,0,1, 0,1,0,0,3,1,0));
        // force_relock together with lock loss; second force inside RESET is ignored
        tbl.push_back(v(1,0,0,2, 0,1,0,0,3,1,0));
        tbl.push_back(v(1,0,1,1, 1,0,1,0,0,2,0));
        tbl.push_back(v(1,1,0,1, 1,0,0,0,0,2,0));
        tbl.push_back(v(1,1,1,1, 1,0,0,0,0,2,0));
        tbl.push_back(v(1,1,0,1, 1,0,0,0,0,2,0));
        tbl.push_back(v(1,1,0,1, 0,0,0,0,1,2,0));
        tbl.push_back(v(1,1,0,1, 0,0,0,0,2,2,0));
        // One-cycle lock drop at STABLE cycle 5 forces full requalification
        tbl.push_back(v(1,1,0,4, 0,0,0,0,2,2,0));
        tbl.push_back(v(1,0,0,1, 0,0,0,0,2,2,0));
        tbl.push_back(v(1,1,0,1, 0,0,0,0,2,2,0));
        tbl.push_back(v(1,1,0,1, 0,0,0,0,1,2,0));
        tbl.push_back(v(1,1,0,1, 0,0,0,0,2,2,0));
        tbl.push_back(v(1,1,0,7, 0,0,0,0,2,2,0));
        tbl.push_back(v(1,1,0,1, 0,1,0,0,3,2,0));
        // rst_n mid-READY and mid-STABLE
        tbl.push_back(v(0,1,0,1, 1,0,0,0,0,0,0));
        tbl.push_back(v(1,1,0,5, 0,0,0,0,2,0,0));
        tbl.push_back(v(0,1,0,1, 1,0,0,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            for (int c = 0; c < int'(tbl[i].hold); c++) begin
                tick(tbl[i].rn, tbl[i].lk, tbl[i].fr);
            end
            chk($sformatf("row%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
        end

        // Lock reaching the synchronizer exactly on the timeout cycle: lock wins, no timeout.
        repeat (RST_CYCLES) tick(1'b1, 1'b0, 1'b0);
        chk("tie_enter_wait", 32'(state), 32'(P_WAIT));
        repeat (LOCK_TIMEOUT - 3) tick(1'b1, 1'b0, 1'b0);
        repeat (2) tick(1'b1, 1'b1, 1'b0);
        chk("tie_still_wait", 32'(state), 32'(P_WAIT));
        tick(1'b1, 1'b1, 1'b0);
        chk("tie_state", 32'(state), 32'(P_STABLE));
        chk("tie_no_pulse", 32'(lock_timeout), 32'(0));
        chk("tie_cnt", 32'(timeout_cnt), 32'(0));

        // No lock ever: timeout every RST_CYCLES+LOCK_TIMEOUT cycles, counter saturates.
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            repeat (RST_CYCLES + LOCK_TIMEOUT - 1) tick(1'b1, 1'b0, 1'b0);
            chk($sformatf("to%0d_quiet", i), 32'(lock_timeout), 32'(0));
            tick(1'b1, 1'b0, 1'b0);
            chk($sformatf("to%0d_pulse", i), 32'(lock_timeout), 32'(1));
            chk($sformatf("to%0d_cnt", i), 32'(timeout_cnt), 32'((i > CNT_MAX) ? CNT_MAX : i));
            chk($sformatf("to%0d_rst", i), 32'(pll_rst), 32'(1));
        end

        // Random lock behaviour with occasional relock requests and resets.
        for (int n = 0; n < 3000; n++) begin
            if (run_left == 0) begin
                lk_r     = ($urandom_range(0, 3) != 0);
                run_left = lk_r ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 45));
            end
            run_left--;
            tick(($urandom_range(0, 499) != 0), lk_r, ($urandom_range(0, 79) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
